// File: rtl/mem_rw_march.sv
// Parametrised single-port RAM with byte enables, selectable read latency and
// read-during-write mode, plus a built-in W0/R0/W1/R1 march self-check engine.
module mem_rw_march #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0,
  parameter logic [7:0]  PAT      = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                ERROR,
  output logic [ADDR_W-1:0]   fail_addr,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [1:0]  LAST  = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, FIN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                drain;
  logic [1:0]          dcnt;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                m_we, m_re, m_chk, m_phase;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata, m_merged;
  logic [NB-1:0]       m_be;

  logic                v1, c1, p1;
  logic [ADDR_W-1:0]   a1;
  logic [DATA_W-1:0]   d1;

  logic                f_v, f_c, f_p;
  logic [ADDR_W-1:0]   f_a;
  logic [DATA_W-1:0]   f_d, f_exp;

  function automatic logic [DATA_W-1:0] pat_word(input logic [ADDR_W-1:0] a);
    logic [7:0] a8;
    a8 = 8'(a);
    return {NB{a8 ^ PAT}};
  endfunction

  // R1 walks the counter upward but addresses ~cnt, so every pass wraps naturally.
  always_comb begin
    m_we    = 1'b0;
    m_re    = 1'b0;
    m_chk   = 1'b0;
    m_phase = 1'b0;
    m_addr  = cnt;
    m_wdata = '0;
    m_be    = '1;
    unique case (state)
      IDLE: begin
        m_we    = we;
        m_re    = re;
        m_addr  = addr;
        m_wdata = wdata;
        m_be    = be;
      end
      W0: m_we = 1'b1;
      R0: begin
        m_re  = ~drain;
        m_chk = 1'b1;
      end
      W1: begin
        m_we    = 1'b1;
        m_wdata = pat_word(cnt);
      end
      R1: begin
        m_re    = ~drain;
        m_chk   = 1'b1;
        m_phase = 1'b1;
        m_addr  = ~cnt;
      end
      default: ;
    endcase
  end

  always_comb begin
    m_merged = mem[m_addr];
    for (int unsigned i = 0; i < NB; i++)
      if (m_be[i]) m_merged[8*i +: 8] = m_wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (m_we)
      for (int unsigned i = 0; i < NB; i++)
        if (m_be[i]) mem[m_addr][8*i +: 8] <= m_wdata[8*i +: 8];
  end

  // The address and check tag travel alongside the read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      c1 <= 1'b0;
      p1 <= 1'b0;
      a1 <= '0;
      d1 <= '0;
    end else begin
      v1 <= m_re;
      c1 <= m_chk;
      p1 <= m_phase;
      a1 <= m_addr;
      if (m_re) d1 <= (RDW_MODE != 0 && m_we) ? m_merged : mem[m_addr];
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                v2, c2, p2;
    logic [ADDR_W-1:0]   a2;
    logic [DATA_W-1:0]   d2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2 <= 1'b0;
        c2 <= 1'b0;
        p2 <= 1'b0;
        a2 <= '0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        c2 <= c1;
        p2 <= p1;
        a2 <= a1;
        if (v1) d2 <= d1;
      end
    end
    assign {f_v, f_c, f_p, f_a, f_d} = {v2, c2, p2, a2, d2};
  end else begin : g_lat1
    assign {f_v, f_c, f_p, f_a, f_d} = {v1, c1, p1, a1, d1};
  end

  assign f_exp  = f_p ? pat_word(f_a) : '0;
  assign rdata  = f_d;
  assign rvalid = f_v & ~f_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      drain     <= 1'b0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ERROR     <= 1'b0;
      fail_addr <= '0;
    end else begin
      done <= 1'b0;
      if (f_v && f_c && f_d != f_exp && !ERROR) begin
        ERROR     <= 1'b1;
        fail_addr <= f_a;
      end
      case (state)
        IDLE: if (start) begin
          state     <= W0;
          cnt       <= '0;
          busy      <= 1'b1;
          ERROR     <= 1'b0;
          fail_addr <= '0;
        end
        W0, W1: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= (state == W0) ? R0 : R1;
        end
        R0, R1: begin
          if (!drain) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
              drain <= 1'b1;
              dcnt  <= '0;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
            if (dcnt == LAST) begin
              drain <= 1'b0;
              if (state == R0) begin
                state <= W1;
              end else begin
                state <= FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
